fetch_prefetch: RTL and testbench

//  Instruction fetch unit with a halfword prefetch queue. Runs ahead of the core on the

---
 rtl/fetch_prefetch.sv | 174 +++++++++++++++++
 tb/tb_fetch_prefetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: fetches 32-bit words over Wishbone into a halfword queue and
// presents complete 16/32/48-bit instructions through a valid/ready handshake.
module fetch_prefetch #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    output logic [31:0] o_wb_addr,
    output logic        o_wb_cyc,
    output logic [3:0]  o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_instruction,
    output logic [31:0] o_immediate,
    output logic [3:0]  o_rb_idx,
    output logic        o_rb_idx_valid,
    output logic [31:0] o_pc,
    output logic [1:0]  o_len,
    output logic        o_error
);
    localparam int unsigned   AW      = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [31:0]   START_PC = RESET_PC & 32'hFFFF_FFFE;

    typedef enum logic [1:0] {ST_REQ = 2'd0, ST_WAIT = 2'd1, ST_HALT = 2'd2} state_t;

    state_t        state_r, state_s;
    logic [15:0]   q_r [DEPTH];
    logic [AW-1:0] rd_ptr_r, wr_ptr_s;
    logic [AW:0]   count_r, free_s, push_amt_s, pop_amt_s;
    logic [31:0]   fetch_pc_r, pc_r, addr_r, flush_pc_s;
    logic          error_r, discard_r;

    logic [15:0]   h0_s, h1_s, h2_s;
    logic [2:0]    amode_s;
    logic [1:0]    len_s;
    logic [31:0]   raw_s, imm_s;
    logic          dec_err_s, valid_s, pop_s, push_s, bus_done_s, bus_err_s;

    assign h0_s       = q_r[rd_ptr_r];
    assign h1_s       = q_r[rd_ptr_r + AW'(1)];
    assign h2_s       = q_r[rd_ptr_r + AW'(2)];
    assign amode_s    = h0_s[2:0];
    assign wr_ptr_s   = rd_ptr_r + count_r[AW-1:0];
    assign free_s     = DEPTH_C - count_r;
    assign flush_pc_s = i_flush_pc & 32'hFFFF_FFFE;

    // Length and immediate decode of the queue head; raw holds only halfwords inside the instruction
    always_comb begin
        len_s = 2'd1;
        raw_s = 32'h0000_0000;
        imm_s = 32'h0000_0000;
        case (amode_s)
            3'b000: begin
                len_s = 2'd1;
            end
            3'b001: begin
                len_s = 2'd2;
                raw_s = {h1_s, 16'h0000};
                imm_s = {{20{h1_s[11]}}, h1_s[11:0]};
            end
            3'b010: begin
                len_s = 2'd3;
                raw_s = {h1_s, h2_s};
                imm_s = {{4{h1_s[11]}}, h1_s[11:0], h2_s};
            end
            3'b011: begin
                len_s = 2'd3;
                raw_s = {h1_s, h2_s};
                imm_s = {h1_s, h2_s};
            end
            default: begin
                len_s = 2'd1;
            end
        endcase
    end

    assign dec_err_s  = (count_r != '0) && amode_s[2];
    assign valid_s    = !amode_s[2] && (count_r >= (AW+1)'(len_s));
    assign pop_s      = valid_s && i_ready && !i_flush;
    assign bus_done_s = (state_r == ST_WAIT) && (i_wb_ack || i_wb_err);
    assign bus_err_s  = bus_done_s && i_wb_err && !discard_r && !i_flush;
    assign push_s     = bus_done_s && i_wb_ack && !i_wb_err && !discard_r && !i_flush;
    assign push_amt_s = push_s ? (fetch_pc_r[1] ? (AW+1)'(1) : (AW+1)'(2)) : '0;
    assign pop_amt_s  = pop_s ? (AW+1)'(len_s) : '0;

    // Fetch FSM next state; a bus cycle in flight always completes before leaving WAIT
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (i_flush)                      state_s = ST_REQ;
                else if (error_r || dec_err_s)    state_s = ST_HALT;
                else if (free_s >= (AW+1)'(2))    state_s = ST_WAIT;
                else                              state_s = ST_REQ;
            end
            ST_WAIT: begin
                if (bus_done_s) state_s = bus_err_s ? ST_HALT : ST_REQ;
                else            state_s = ST_WAIT;
            end
            ST_HALT: begin
                if (i_flush) state_s = ST_REQ;
                else         state_s = ST_HALT;
            end
            default: state_s = ST_REQ;
        endcase
    end

    // Queue, program counters, bus address and sticky error; flush overrides push and pop
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r    <= ST_REQ;
            q_r        <= '{default: 16'h0000};
            rd_ptr_r   <= '0;
            count_r    <= '0;
            fetch_pc_r <= START_PC;
            pc_r       <= START_PC;
            addr_r     <= 32'h0000_0000;
            error_r    <= 1'b0;
            discard_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (state_r == ST_REQ && state_s == ST_WAIT)
                addr_r <= fetch_pc_r & 32'hFFFF_FFFC;
            if (i_flush) begin
                rd_ptr_r   <= '0;
                count_r    <= '0;
                fetch_pc_r <= flush_pc_s;
                pc_r       <= flush_pc_s;
                error_r    <= 1'b0;
                discard_r  <= (state_r == ST_WAIT) && !bus_done_s;
            end else begin
                if (push_s) begin
                    if (fetch_pc_r[1]) begin
                        q_r[wr_ptr_s] <= i_wb_dat[15:0];
                    end else begin
                        q_r[wr_ptr_s]          <= i_wb_dat[31:16];
                        q_r[wr_ptr_s + AW'(1)] <= i_wb_dat[15:0];
                    end
                    fetch_pc_r <= (fetch_pc_r & 32'hFFFF_FFFC) + 32'd4;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(len_s);
                    pc_r     <= pc_r + {29'd0, len_s, 1'b0};
                end
                count_r <= count_r + push_amt_s - pop_amt_s;
                if (bus_err_s || dec_err_s) error_r <= 1'b1;
                if (bus_done_s) discard_r <= 1'b0;
            end
        end
    end

    assign o_wb_cyc       = (state_r == ST_WAIT);
    assign o_wb_stb       = o_wb_cyc ? 4'b1111 : 4'b0000;
    assign o_wb_addr      = addr_r;
    assign o_wb_we        = 1'b0;
    assign o_wb_dat       = 32'h0000_0000;
    assign o_valid        = valid_s;
    assign o_instruction  = valid_s ? h0_s : 16'h0000;
    assign o_immediate    = valid_s ? imm_s : 32'h0000_0000;
    assign o_rb_idx       = valid_s ? raw_s[31:28] : 4'h0;
    assign o_rb_idx_valid = valid_s && (amode_s == 3'b001 || amode_s == 3'b010);
    assign o_len          = valid_s ? len_s : 2'd0;
    assign o_pc           = pc_r;
    assign o_error        = error_r;
endmodule

// File: tb/tb_fetch_prefetch.sv
// Self-checking bench for fetch_prefetch: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural queue/PC model.
module tb_fetch_prefetch;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, rst;
    logic [31:0] o_wb_addr, o_wb_dat, i_wb_dat, i_flush_pc, o_immediate, o_pc;
    logic        o_wb_cyc, o_wb_we, i_wb_ack, i_wb_err, i_flush, o_valid, i_ready;
    logic        o_rb_idx_valid, o_error;
    logic [3:0]  o_wb_stb, o_rb_idx;
    logic [15:0] o_instruction;
    logic [1:0]  o_len;

    fetch_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_1000)) dut (
        .i_clk(clk), .i_reset(rst),
        .o_wb_addr(o_wb_addr), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
        .o_wb_dat(o_wb_dat), .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack), .i_wb_err(i_wb_err),
        .i_flush(i_flush), .i_flush_pc(i_flush_pc), .o_valid(o_valid), .i_ready(i_ready),
        .o_instruction(o_instruction), .o_immediate(o_immediate), .o_rb_idx(o_rb_idx),
        .o_rb_idx_valid(o_rb_idx_valid), .o_pc(o_pc), .o_len(o_len), .o_error(o_error)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    logic [15:0] dmem [int unsigned];

    typedef struct packed {
        logic [1:0]  len;
        logic [15:0] instr;
        logic [31:0] imm;
        logic [3:0]  rb;
        logic        rbv;
        logic        bad;
    } dec_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  len;
        logic [15:0] instr;
        logic [31:0] imm;
        logic [3:0]  rb;
        logic        rbv;
    } hs_t;
    hs_t hs_q[$];

    // behavioural model state
    logic [31:0] m_pc, m_fpc, m_addr;
    int          m_cnt;
    bit          m_err, m_busy, m_disc;

    // responder state
    int wait_min = 0, wait_max = 0, cur_wait = 0, wcnt = 0;
    bit in_xfer = 1'b0, err_arm = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            if (failures <= 50)
                $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // memory: directed entries first, else a hashed pattern; reserved amodes only in 0x5000-0x50FF
    function automatic logic [15:0] mem_hw(input logic [31:0] a);
        logic [31:0] x;
        if (dmem.exists(a)) return dmem[a];
        x = (a >> 1) * 32'h9E37_79B1;
        x = x ^ (x >> 15);
        if (a[31:8] != 24'h000050) x[2] = 1'b0;
        return x[15:0];
    endfunction

    function automatic dec_t decode_at(input logic [31:0] pc);
        dec_t d;
        logic [15:0] h0, h1, h2;
        logic [31:0] raw;
        h0 = mem_hw(pc); h1 = mem_hw(pc + 32'd2); h2 = mem_hw(pc + 32'd4);
        raw = {h1, h2};
        d = '0;
        d.instr = h0; d.len = 2'd1; d.bad = h0[2];
        if (h0[2:0] == 3'd1) begin
            d.len = 2'd2; d.imm = {{20{h1[11]}}, h1[11:0]}; d.rb = h1[15:12]; d.rbv = 1'b1;
        end else if (h0[2:0] == 3'd2) begin
            d.len = 2'd3; d.imm = {{4{raw[27]}}, raw[27:0]}; d.rb = h1[15:12]; d.rbv = 1'b1;
        end else if (h0[2:0] == 3'd3) begin
            d.len = 2'd3; d.imm = raw; d.rb = h1[15:12];
        end
        return d;
    endfunction

    task automatic model_reset();
        m_pc = 32'h1000; m_fpc = 32'h1000; m_addr = 32'h0;
        m_cnt = 0; m_err = 1'b0; m_busy = 1'b0; m_disc = 1'b0;
        in_xfer = 1'b0; wcnt = 0; err_arm = 1'b0;
    endtask

    task automatic compare();
        dec_t d;
        bit ev;
        d = decode_at(m_pc);
        ev = !d.bad && (m_cnt >= int'(d.len));
        chk("cyc", {31'd0, o_wb_cyc}, {31'd0, m_busy});
        chk("stb", {28'd0, o_wb_stb}, m_busy ? 32'hF : 32'h0);
        if (m_busy) chk("addr", o_wb_addr, m_addr);
        chk("we_dat", o_wb_dat | {31'd0, o_wb_we}, 32'h0);
        chk("valid", {31'd0, o_valid}, {31'd0, ev});
        chk("pc", o_pc, m_pc);
        chk("error", {31'd0, o_error}, {31'd0, m_err});
        chk("rb_valid", {31'd0, o_rb_idx_valid}, {31'd0, ev && d.rbv});
        if (ev) begin
            chk("instr", {16'd0, o_instruction}, {16'd0, d.instr});
            chk("len", {30'd0, o_len}, {30'd0, d.len});
            chk("imm", o_immediate, d.imm);
            chk("rb", {28'd0, o_rb_idx}, {28'd0, d.rb});
        end
    endtask

    task automatic model_step(input logic rdy, input logic fl, input logic [31:0] fpc,
                              input logic ack, input logic err);
        dec_t d;
        bit v, dec, busy_n, disc_n, err_n;
        int cnt_n;
        logic [31:0] pc_n, fpc_n;
        d = decode_at(m_pc);
        v = !d.bad && (m_cnt >= int'(d.len));
        dec = (m_cnt >= 1) && d.bad;
        pc_n = m_pc; fpc_n = m_fpc; cnt_n = m_cnt;
        busy_n = m_busy; disc_n = m_disc; err_n = m_err | dec;
        if (m_busy) begin
            if (ack || err) begin
                busy_n = 1'b0; disc_n = 1'b0;
                if (!m_disc && !fl) begin
                    if (err) err_n = 1'b1;
                    else begin
                        cnt_n += m_fpc[1] ? 1 : 2;
                        fpc_n = (m_fpc & 32'hFFFF_FFFC) + 32'd4;
                    end
                end
            end else if (fl) disc_n = 1'b1;
        end else if (!fl && !m_err && !dec && (DEPTH - m_cnt) >= 2) begin
            busy_n = 1'b1;
            m_addr = m_fpc & 32'hFFFF_FFFC;
        end
        if (v && rdy && !fl) begin
            pc_n = m_pc + 32'(2 * int'(d.len));
            cnt_n -= int'(d.len);
        end
        if (fl) begin
            cnt_n = 0; pc_n = fpc & 32'hFFFF_FFFE; fpc_n = pc_n; err_n = 1'b0;
        end
        m_pc = pc_n; m_fpc = fpc_n; m_cnt = cnt_n;
        m_busy = busy_n; m_disc = disc_n; m_err = err_n;
    endtask

    task automatic respond(output logic ack, output logic err);
        ack = 1'b0; err = 1'b0;
        if (o_wb_cyc) begin
            if (!in_xfer) begin
                in_xfer = 1'b1; wcnt = 0;
                cur_wait = $urandom_range(wait_max, wait_min);
            end
            if (wcnt >= cur_wait) begin
                if (err_arm) begin err = 1'b1; err_arm = 1'b0; end
                else ack = 1'b1;
                in_xfer = 1'b0;
            end else wcnt++;
        end
        i_wb_dat = ack ? {mem_hw(o_wb_addr), mem_hw(o_wb_addr + 32'd2)} : 32'h0;
    endtask

    // one clock: check outputs, drive inputs, advance the model, move to the next negedge
    task automatic cycle(input logic rdy, input logic fl, input logic [31:0] fpc);
        logic ack, err;
        hs_t h;
        compare();
        respond(ack, err);
        i_ready = rdy; i_flush = fl; i_flush_pc = fpc; i_wb_ack = ack; i_wb_err = err;
        if (o_valid && rdy && !fl) begin
            h.pc = o_pc; h.len = o_len; h.instr = o_instruction;
            h.imm = o_immediate; h.rb = o_rb_idx; h.rbv = o_rb_idx_valid;
            hs_q.push_back(h);
        end
        model_step(rdy, fl, fpc, ack, err);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cyc_seen;
        logic [31:0] tgt;
        rst = 1'b1; i_ready = 1'b0; i_flush = 1'b0; i_flush_pc = 32'h0;
        i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = 32'h0;
        dmem[32'h1000] = 16'h1230; dmem[32'h1002] = 16'h4561; dmem[32'h1004] = 16'h5800;
        dmem[32'h1006] = 16'h0003; dmem[32'h1008] = 16'hDEAD; dmem[32'h100A] = 16'hBEEF;
        dmem[32'h100C] = 16'h0000; dmem[32'h100E] = 16'h1232; dmem[32'h1010] = 16'h9ABC;
        dmem[32'h1012] = 16'hDEF0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("rst_pc", o_pc, 32'h1000);
        chk("rst_cyc_stb", {27'd0, o_wb_stb, o_wb_cyc}, 32'h0);
        chk("rst_valid_err", {30'd0, o_valid, o_error}, 32'h0);
        chk("rst_outs", {o_wb_addr[15:0], o_instruction} | {30'd0, o_len} | {31'd0, o_rb_idx_valid}, 32'h0);

        // zero-wait fetch from 0x1000, consumer always ready
        n = 0;
        while (hs_q.size() < 5 && n < 100) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        chk("a_hs_count", (hs_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        if (hs_q.size() >= 5) begin
            chk("a0_pc", hs_q[0].pc, 32'h1000);      chk("a0_len", {30'd0, hs_q[0].len}, 32'd1);
            chk("a0_instr", {16'd0, hs_q[0].instr}, 32'h1230);
            chk("a1_pc", hs_q[1].pc, 32'h1002);      chk("a1_len", {30'd0, hs_q[1].len}, 32'd2);
            chk("a1_imm", hs_q[1].imm, 32'hFFFF_F800);
            chk("a1_rb", {27'd0, hs_q[1].rb, hs_q[1].rbv}, 32'h0B);
            chk("a2_pc", hs_q[2].pc, 32'h1006);      chk("a2_len", {30'd0, hs_q[2].len}, 32'd3);
            chk("a2_imm", hs_q[2].imm, 32'hDEAD_BEEF);
            chk("a2_rbv", {31'd0, hs_q[2].rbv}, 32'd0);
            chk("a3_pc", hs_q[3].pc, 32'h100C);
            chk("a4_imm", hs_q[4].imm, 32'hFABC_DEF0);
            chk("a4_rb", {27'd0, hs_q[4].rb, hs_q[4].rbv}, 32'h13);
        end

        // consumer stalls: queue fills, bus goes quiet
        cyc_seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (i >= 15 && o_wb_cyc) cyc_seen++;
            cycle(1'b0, 1'b0, 32'h0);
        end
        chk("b_quiet_bus", cyc_seen, 0);
        chk("b_valid_held", {31'd0, o_valid}, 32'd1);
        cyc_seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (o_wb_cyc) cyc_seen++;
            cycle(1'b1, 1'b0, 32'h0);
        end
        chk("b_resume", (cyc_seen > 0) ? 32'd1 : 32'd0, 32'd1);

        // flush to 0x2002 while a slow transfer is outstanding
        wait_min = 4; wait_max = 4;
        n = 0;
        while (!o_wb_cyc && n < 20) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        chk("c_in_wait", {31'd0, o_wb_cyc}, 32'd1);
        cycle(1'b1, 1'b1, 32'h0000_2002);
        wait_min = 0; wait_max = 0;
        n = 0;
        while (o_wb_cyc && n < 20) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        n = 0;
        while (!o_wb_cyc && n < 20) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        chk("c_new_addr", o_wb_addr, 32'h2000);
        n = 0;
        while (!o_valid && n < 20) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        chk("c_first_pc", o_pc, 32'h2002);

        // bus error halts fetching until a flush
        err_arm = 1'b1;
        n = 0;
        while (!o_error && n < 40) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        chk("d_err_set", {31'd0, o_error}, 32'd1);
        cyc_seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_wb_cyc) cyc_seen++;
            cycle(1'b0, 1'b0, 32'h0);
        end
        chk("d_halted", cyc_seen, 0);
        cycle(1'b0, 1'b1, 32'h0000_1001);
        chk("d_err_clear", {31'd0, o_error}, 32'd0);
        n = 0;
        while (!o_valid && n < 10) begin cycle(1'b0, 1'b0, 32'h0); n++; end
        chk("d_latency", n + 1, 3);
        chk("d_pc", o_pc, 32'h1000);

        // randomized traffic
        wait_min = 0; wait_max = 3;
        for (int i = 0; i < 3000; i++) begin
            logic rdy, fl;
            rdy = ($urandom_range(9, 0) < 7);
            fl  = ($urandom_range(49, 0) == 0);
            case ($urandom_range(15, 0))
                0:       tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                1:       tgt = 32'h5000 + 32'($urandom_range(255, 0));
                default: tgt = 32'h3000 + 32'($urandom_range(4095, 0));
            endcase
            if (!err_arm && $urandom_range(59, 0) == 0) err_arm = 1'b1;
            cycle(rdy, fl, tgt);
        end

        // reset in the middle of a bus cycle
        wait_min = 6; wait_max = 6; err_arm = 1'b0;
        cycle(1'b1, 1'b1, 32'h0000_3000);
        n = 0;
        while (!o_wb_cyc && n < 20) begin cycle(1'b1, 1'b0, 32'h0); n++; end
        chk("f_in_wait", {31'd0, o_wb_cyc}, 32'd1);
        rst = 1'b1;
        #1;
        chk("f_async_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("f_async_pc", o_pc, 32'h1000);
        @(negedge clk);
        rst = 1'b0; i_flush = 1'b0; i_wb_ack = 1'b0; i_wb_err = 1'b0;
        model_reset();
        wait_min = 0; wait_max = 1;
        for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
